// File: rtl/demux2_pkg.sv
// Shared defaults and helpers for the two-way stream demultiplexer.
// Optional feature macro: DEMUX2_CNT_EN (per-port accepted-transfer counters).
package demux2_pkg;

  localparam int W_DEF     = 4;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W     = 8;

  // Pointer width for a FIFO of n entries (n is a power of two).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with head-of-queue output. A full FIFO refuses a push
// even when it pops in the same cycle, so there is no pass-through path.
module fifo_sync
  import demux2_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Storage is cleared on reset so the head reads 0 while empty after reset.
  assign head    = mem[rd_ptr];

  // Storage, pointers (wrap naturally at DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Two-way stream demultiplexer: each accepted input word is routed by Sel
// (1 -> port 1, 0 -> port 2) into an independent per-port FIFO, so a stall
// on one port never blocks traffic to the other.
// Optional feature macro: DEMUX2_CNT_EN adds cnt1/cnt2, wrapping 8-bit
// counts of accepted input transfers per port.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     Din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Sel,
  output logic [W-1:0]     Dout1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [W-1:0]     Dout2,
  output logic             out2_valid,
  input  logic             out2_ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
`endif
);

  logic full1, full2, empty1, empty2;
  logic push1, push2;

  // Readiness depends only on the selected FIFO, never on in_valid.
  assign in_ready = Sel ? !full1 : !full2;
  assign push1    = in_valid && in_ready && Sel;
  assign push2    = in_valid && in_ready && !Sel;

  assign out1_valid = !empty1;
  assign out2_valid = !empty2;

  fifo_sync #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .din   (Din),
    .pop   (out1_ready),
    .full  (full1),
    .empty (empty1),
    .head  (Dout1)
  );

  fifo_sync #(.W(W), .DEPTH(DEPTH)) u_fifo2 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push2),
    .din   (Din),
    .pop   (out2_ready),
    .full  (full2),
    .empty (empty2),
    .head  (Dout2)
  );

`ifdef DEMUX2_CNT_EN
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  // Per-port accepted-transfer counters, wrapping 255 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else begin
      if (push1) cnt1 <= cnt1 + CNT_INC;
      if (push2) cnt2 <= cnt2 + CNT_INC;
    end
  end
`else
  // No counters in this build.
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: a per-port queue model predicts
// in_ready, valids and head data every cycle.
module tb_demux2_stream;

  localparam int W     = 4;
  localparam int DEPTH = 2;

  logic         clk = 0;
  logic         rst_n = 1;
  logic [W-1:0] Din = '0;
  logic         in_valid = 0;
  logic         in_ready;
  logic         Sel = 0;
  logic [W-1:0] Dout1, Dout2;
  logic         out1_valid, out2_valid;
  logic         out1_ready = 0, out2_ready = 0;
`ifdef DEMUX2_CNT_EN
  logic [7:0]   cnt1, cnt2;
`endif

  demux2_stream #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Din        (Din),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Sel        (Sel),
    .Dout1      (Dout1),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .Dout2      (Dout2),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt1       (cnt1),
    .cnt2       (cnt2)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;
  bit mon_en = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: check outputs against the model, then apply this cycle's transfers.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy;
      exp_rdy = Sel ? (q1.size() < DEPTH) : (q2.size() < DEPTH);
      chk("in_ready", in_ready, exp_rdy);
      chk("out1_valid", out1_valid, q1.size() != 0);
      chk("out2_valid", out2_valid, q2.size() != 0);
      if (q1.size() != 0) chk("dout1", Dout1, q1[0]);
      if (q2.size() != 0) chk("dout2", Dout2, q2[0]);
      if (out1_ready && q1.size() != 0) void'(q1.pop_front());
      if (out2_ready && q2.size() != 0) void'(q2.pop_front());
      if (in_valid && exp_rdy) begin
        if (Sel) q1.push_back(Din);
        else     q2.push_back(Din);
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out2_valid", out2_valid, 0);
    chk("rst_dout1", Dout1, 0);
    chk("rst_dout2", Dout2, 0);
    q1.delete();
    q2.delete();
    step();
    rst_n = 1;
    Sel = 0; #1 chk("rst_in_ready_sel0", in_ready, 1);
    Sel = 1; #1 chk("rst_in_ready_sel1", in_ready, 1);
    mon_en = 1;
  endtask

  // Hold a word on the input until the model records its acceptance.
  task automatic send(input logic s, input logic [W-1:0] d, input bit rnd);
    int tgt;
    Sel = s; Din = d; in_valid = 1;
    tgt = acc_cnt + 1;
    for (int i = 0; i < 64 && acc_cnt < tgt; i++) begin
      if (rnd) begin
        out1_ready = 1'($urandom_range(0, 1));
        out2_ready = 1'($urandom_range(0, 1));
      end
      step();
    end
    if (acc_cnt < tgt) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0; out1_ready = 1; out2_ready = 1;
    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) step();
    step();
    chk("drain_out1_valid", out1_valid, 0);
    chk("drain_out2_valid", out2_valid, 0);
  endtask

  initial begin
    step();
    do_reset();

    // Single word to port 1, visible the cycle after acceptance only.
    Din = 4'hA; Sel = 1; in_valid = 1; out1_ready = 1; out2_ready = 0;
    step();
    in_valid = 0;
    chk("p1_first_valid", out1_valid, 1);
    chk("p1_first_data", Dout1, 4'hA);
    chk("p2_idle_valid", out2_valid, 0);
    step();
    chk("p1_valid_once", out1_valid, 0);

    // Fill port 2 while stalled; port 1 still accepts.
    out1_ready = 0; out2_ready = 0;
    send(0, 4'h3, 0);
    send(0, 4'h5, 0);
    Sel = 0; #1 chk("p2_full_ready", in_ready, 0);
    Sel = 1; #1 chk("p1_free_ready", in_ready, 1);
    send(1, 4'h7, 0);
    drain();

    // Full port 1 refuses a push in the same cycle as a pop.
    do_reset();
    out1_ready = 0; out2_ready = 0;
    send(1, 4'h1, 0);
    send(1, 4'h2, 0);
    Sel = 1; #1 chk("p1_full_ready", in_ready, 0);
    step();
    Din = 4'h9; Sel = 1; in_valid = 1; out1_ready = 1;
    step();
    in_valid = 0; out1_ready = 0;
    chk("refuse_valid", out1_valid, 1);
    chk("refuse_head", Dout1, 4'h2);
    chk("refuse_ready", in_ready, 1);
    out1_ready = 1;
    step();
    chk("refuse_empty", out1_valid, 0);
    out1_ready = 0;

    // Alternating stream with random backpressure.
    send(1, 4'h1, 1);
    send(0, 4'h2, 1);
    send(1, 4'h3, 1);
    send(0, 4'h4, 1);
    drain();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      Sel = 1'($urandom_range(0, 1));
      Din = 4'($urandom_range(0, 15));
      in_valid = 1'($urandom_range(0, 1));
      out1_ready = ($urandom_range(0, 3) != 0);
      out2_ready = ($urandom_range(0, 3) == 0);
      step();
    end
    drain();

    // Reset mid-stream with both FIFOs occupied.
    out1_ready = 0; out2_ready = 0;
    send(1, 4'hB, 0);
    send(0, 4'hC, 0);
    send(1, 4'hD, 0);
    do_reset();
    step();
    chk("post_rst_v1", out1_valid, 0);
    chk("post_rst_v2", out2_valid, 0);

`ifdef DEMUX2_CNT_EN
    do_reset();
    begin
      int tgt;
      tgt = acc_cnt + 257;
      Sel = 1; in_valid = 1; out1_ready = 1; out2_ready = 0;
      for (int i = 0; i < 600 && acc_cnt < tgt; i++) begin
        Din = 4'(i);
        step();
      end
      in_valid = 0;
      if (acc_cnt < tgt) chk("cnt_timeout", 0, 1);
      chk("cnt1_wrap", cnt1, 1);
      chk("cnt2_zero", cnt2, 0);
    end
    drain();
`endif

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter W, default 4, data width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output FIFO; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Din  input  W  input data.
REQ-006 in_valid  input  1  Din valid.
REQ-007 in_ready  output  1  block accepts Din this cycle.
REQ-008 Sel  input  1  route select; 1 -> port 1, 0 -> port 2; sampled with Din.
REQ-009 Dout1 / Dout2  output  W  head data of port-1 / port-2 FIFO.
REQ-010 out1_valid / out2_valid  output  1  head entry present.
REQ-011 out1_ready / out2_ready  input  1  sink takes head this cycle.

Function
REQ-012 Input transfer occurs when in_valid && in_ready; Din is pushed into the FIFO chosen by Sel in that cycle.
REQ-013 in_ready = NOT full(FIFO chosen by current Sel); combinational from Sel and FIFO state, no dependence on in_valid.
REQ-014 Full FIFO refuses push even when its port pops the same cycle; no pass-through.
REQ-015 Output transfer on port k occurs when outk_valid && outk_ready; head entry removed at that edge.
REQ-016 outk_valid = FIFO k not empty; Doutk = FIFO k head; Doutk value while outk_valid=0 is don't-care.
REQ-017 Latency: data accepted at edge N appears with outk_valid=1 after edge N, i.e. visible in cycle N+1 when FIFO was empty.
REQ-018 Order preserved per port; no ordering relation between ports.
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, both operations take effect.
REQ-020 Pop on empty FIFO ignored; pointers wrap modulo DEPTH; occupancy range 0..DEPTH.
REQ-021 Ports independent: stall on port 1 never blocks transfers routed to port 2.
REQ-022 Data never altered; no width change between Din and Doutk.

Reset
REQ-023 rst_n low immediately empties both FIFOs: out1_valid=0, out2_valid=0, pointers and occupancy 0.
REQ-024 Dout1/Dout2 reset to 0.
REQ-025 Reset mid-operation discards all buffered data; first cycle after release in_ready=1 for either Sel.

Configuration
REQ-026 Macro DEMUX2_CNT_EN: defined -> outputs cnt1, cnt2 (8 bits each) count accepted input transfers per port, reset to 0, wrap 255->0.
REQ-027 DEMUX2_CNT_EN undefined -> cnt1/cnt2 ports and counter logic absent; all other behaviour identical.

Structure
REQ-028 Package demux2_pkg holds W and DEPTH defaults, counter width 8, and pointer width function clog2(DEPTH).
REQ-029 Sub-module fifo_sync (parameters W, DEPTH; push/pop/full/empty/head) instantiated once per port.

Verification
REQ-030 Reset, then Din=4'hA, Sel=1, in_valid=1 one cycle, out1_ready=1 -> Dout1=4'hA, out1_valid=1 next cycle only, out2_valid stays 0.
REQ-031 out2_ready=0, push 3,5 with Sel=0 -> in_ready=0 with Sel=0, in_ready=1 with Sel=1; push 7 to port 1 succeeds.
REQ-032 Port 1 full, out1_ready=1, push with Sel=1 same cycle -> push refused, occupancy drops to 1.
REQ-033 Streams 1,2,3,4 alternating Sel, both readies toggling randomly -> port 1 sees 1,3; port 2 sees 2,4 in order.
REQ-034 rst_n low mid-stream with both FIFOs holding data -> both valids 0 immediately, Dout1=Dout2=0, in_ready=1 after release.
REQ-035 With DEMUX2_CNT_EN, 257 transfers to port 1 -> cnt1=1, cnt2=0.
